// File: rtl/alct_oneshot_pkg.sv
// Shared types and default sizing for the per-layer anode one-shot.
package alct_oneshot_pkg;

  localparam int DEF_NCH = 112;
  localparam int DEF_CW  = 4;

  typedef enum logic [1:0] {
    OS_IDLE,
    OS_PULSE,
    OS_DEAD,
    OS_WAIT_LOW
  } os_state_t;

endpackage

// File: rtl/oneshot_chan.sv
// Single anode channel: edge detect, programmable pulse, dead time and rearm.
module oneshot_chan
  import alct_oneshot_pkg::*;
#(
  parameter int CW          = DEF_CW,
  parameter bit REQUIRE_LOW = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ly_i,
  input  logic          mask_i,
  input  logic [CW-1:0] pulse_len_i,
  input  logic [CW-1:0] dead_len_i,
  input  logic          trig_stop_i,
  output logic          lyr_o,
  output logic          fire_o
);

  localparam os_state_t REARM_ST = REQUIRE_LOW ? OS_WAIT_LOW : OS_IDLE;

  os_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ly_d_q, ly_d_d;

  // A programmed length of zero still yields a one-clock pulse.
  function automatic logic [CW-1:0] pulse_cnt(input logic [CW-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

  // ly_d resets high so a line already asserted must be seen low before it can fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OS_IDLE;
      cnt_q   <= '0;
      ly_d_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ly_d_q  <= ly_d_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ly_d_d  = trig_stop_i ? ly_d_q : ly_i;
    if (!trig_stop_i) begin
      unique case (state_q)
        OS_IDLE: begin
          if (ly_i && !ly_d_q && !mask_i) begin
            state_d = OS_PULSE;
            cnt_d   = pulse_cnt(pulse_len_i);
          end
        end
        OS_PULSE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (dead_len_i != '0) begin
            state_d = OS_DEAD;
            cnt_d   = dead_len_i - 1'b1;
          end else begin
            state_d = REARM_ST;
          end
        end
        OS_DEAD: begin
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          else             state_d = REARM_ST;
        end
        OS_WAIT_LOW: begin
          if (!ly_i) state_d = OS_IDLE;
        end
        default: state_d = OS_IDLE;
      endcase
    end
  end

  always_comb begin
    lyr_o  = (state_q == OS_PULSE);
    fire_o = (state_q == OS_IDLE) && (state_d == OS_PULSE);
  end

endmodule

// File: rtl/layer_oneshot_gen2.sv
// Per-layer array of anode one-shots with a registered count of channels fired per edge.
module layer_oneshot_gen2
  import alct_oneshot_pkg::*;
#(
  parameter int NCH         = DEF_NCH,
  parameter int CW          = DEF_CW,
  parameter bit REQUIRE_LOW = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NCH-1:0]             ly,
  input  logic [NCH-1:0]             mask,
  input  logic [CW-1:0]              pulse_len,
  input  logic [CW-1:0]              dead_len,
  input  logic                       trig_stop,
  output logic [NCH-1:0]             lyr,
  output logic [$clog2(NCH+1)-1:0]   fire_cnt
);

  localparam int FW = $clog2(NCH+1);

  logic [NCH-1:0] fire;
  logic [FW-1:0]  fire_cnt_q, fire_cnt_d;

  for (genvar g = 0; g < NCH; g++) begin : gen_chan
    oneshot_chan #(
      .CW          (CW),
      .REQUIRE_LOW (REQUIRE_LOW)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .ly_i        (ly[g]),
      .mask_i      (mask[g]),
      .pulse_len_i (pulse_len),
      .dead_len_i  (dead_len),
      .trig_stop_i (trig_stop),
      .lyr_o       (lyr[g]),
      .fire_o      (fire[g])
    );
  end

  // Channels never fire while frozen, so the sum is already zero under trig_stop.
  always_comb begin
    fire_cnt_d = '0;
    for (int i = 0; i < NCH; i++) begin
      fire_cnt_d = fire_cnt_d + FW'(fire[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fire_cnt_q <= '0;
    else        fire_cnt_q <= fire_cnt_d;
  end

  assign fire_cnt = fire_cnt_q;

endmodule
